// File: rtl/slew_pkg.sv
// Shared types for the slew-rate limiter.
package slew_pkg;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN
  } step_t;

endpackage

// File: rtl/slew.sv
// Slew-rate limiter: out_val walks toward in_set by at most one LSB per tick,
// with optional shortest-path (modular) tracking for phase-like quantities.
module slew
  import slew_pkg::*;
#(
  parameter int dw = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] in_set,
  input  logic          enable,
  input  logic          wrap,
  input  logic          tick,
  output logic [dw-1:0] out_val,
  output logic          motion
);

  localparam logic [dw-1:0] LSB = dw'(1);

  logic [dw-1:0] diff;
  logic [dw-1:0] next_val;
  step_t         dir;

  assign diff = in_set - out_val;

  // Linear mode uses the full unsigned compare so it can never wrap through 0 or max;
  // modular mode uses the diff MSB, which also sends the half-circle tie downward.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dir = STEP_HOLD;
    if (diff != '0) begin
      if (wrap) dir = diff[dw-1] ? STEP_DOWN : STEP_UP;
      else      dir = (in_set > out_val) ? STEP_UP : STEP_DOWN;
    end
  end

  always_comb begin
    next_val = out_val;
    if (!enable) begin
      next_val = in_set;
    end else if (tick) begin
      case (dir)
        STEP_UP:   next_val = out_val + LSB;
        STEP_DOWN: next_val = out_val - LSB;
        default:   next_val = out_val;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_val <= '0;
      motion  <= 1'b0;
    end else begin
      out_val <= next_val;
      motion  <= (next_val != in_set);
    end
  end

endmodule

// File: tb/tb_slew.sv
// Randomized scoreboard bench for slew: a behavioural model queues the expected
// output per cycle and an independent monitor pops and compares after each edge.
module tb_slew;

  localparam int DW = 5;
  localparam int MOD = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_set = '0;
  logic          enable = 1'b0;
  logic          wrap = 1'b0;
  logic          tick = 1'b0;
  logic [DW-1:0] out_val;
  logic          motion;

  slew #(.dw(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_set  (in_set),
    .enable  (enable),
    .wrap    (wrap),
    .tick    (tick),
    .out_val (out_val),
    .motion  (motion)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit mot;
    bit en;
    bit rst;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   m_val = 0;   // model output value
  int   m_set = 0;   // setpoint applied in the previous cycle

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances with the same inputs the DUT sees.
  task automatic cyc(input bit r, input bit en, input bit wr, input bit tk, input int s);
    exp_t e;
    int d;
    @(negedge clk);
    if (m_val == m_set && s != m_set)
      check("conv_prev_setpoint", int'(out_val), m_set);
    rst    = r;
    enable = en;
    wrap   = wr;
    tick   = tk;
    in_set = s[DW-1:0];
    if (r) begin
      m_val = 0;
    end else if (!en) begin
      m_val = s;
    end else if (tk && m_val != s) begin
      if (wr) begin
        d = (s - m_val + MOD) % MOD;
        m_val = (d < MOD / 2) ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
      end else begin
        m_val = (s > m_val) ? m_val + 1 : m_val - 1;
      end
    end
    m_set = s;
    e.val = m_val;
    e.mot = !r && (m_val != s);
    e.en  = en;
    e.rst = r;
    q.push_back(e);
  endtask

  // Monitor: compare after every active edge, plus the per-cycle step-size rule.
  int prev_out = 0;
  bit have_prev = 1'b0;
  always begin
    exp_t e;
    int step;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("out_val", int'(out_val), e.val);
      check("motion", int'(motion), int'(e.mot));
      if (have_prev && e.en && !e.rst) begin
        step = (prev_out - int'(out_val) + MOD) % MOD;
        check("step_size_ok", int'(step == 0 || step == 1 || step == MOD - 1), 1);
      end
      prev_out  = int'(out_val);
      have_prev = 1'b1;
    end
  end

  initial begin
    int s;
    bit en, wr, r;

    // Reset, then bypass to 15.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 7);
    cyc(0, 0, 0, 0, 15);
    cyc(0, 0, 0, 1, 15);

    // Tick every 4th clock, 15 -> 10.
    for (int i = 0; i < 24; i++) cyc(0, 1, 0, (i % 4) == 3, 10);

    // Linear: 10 -> 30 with no wrap through 31/0.
    for (int i = 0; i < 23; i++) cyc(0, 1, 0, 1, 30);

    // Modular: 30 -> 10 via 31,0,1,... (12 ticks).
    cyc(0, 0, 1, 0, 30);
    for (int i = 0; i < 14; i++) cyc(0, 1, 1, 1, 10);

    // Modular tie: 0 -> 16 steps downward.
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(0, 1, 1, 1, 16);

    // Enable 1->0 mid-motion jumps; 0->1 resumes from current value.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 2);
    cyc(0, 0, 0, 1, 25);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, 5);

    // Randomized traffic.
    s = 5; en = 1; wr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) s = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 31) == 0) wr = ~wr;
      en = ($urandom_range(0, 19) != 0);
      r  = ($urandom_range(0, 499) == 0);
      cyc(r, en, wr, $urandom_range(0, 2) != 0, s);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
